// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle shared by the SRAM responder and whatever master drives it.
// The master modport sources addresses and write data, the slave modport answers.
interface axi4_if #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH    = 128,
   parameter int AXI4_ID_WIDTH      = 4
);
   logic [AXI4_ID_WIDTH-1:0]        awid;
   logic [AXI4_ADDRESS_WIDTH-1:0]   awaddr;
   logic [7:0]                      awlen;
   logic [2:0]                      awsize;
   logic [1:0]                      awburst;
   logic                            awvalid;
   logic                            awready;

   logic [AXI4_DATA_WIDTH-1:0]      wdata;
   logic [AXI4_DATA_WIDTH/8-1:0]    wstrb;
   logic                            wlast;
   logic                            wvalid;
   logic                            wready;

   logic [AXI4_ID_WIDTH-1:0]        bid;
   logic [1:0]                      bresp;
   logic                            bvalid;
   logic                            bready;

   logic [AXI4_ID_WIDTH-1:0]        arid;
   logic [AXI4_ADDRESS_WIDTH-1:0]   araddr;
   logic [7:0]                      arlen;
   logic [2:0]                      arsize;
   logic [1:0]                      arburst;
   logic                            arvalid;
   logic                            arready;

   logic [AXI4_ID_WIDTH-1:0]        rid;
   logic [AXI4_DATA_WIDTH-1:0]      rdata;
   logic [1:0]                      rresp;
   logic                            rlast;
   logic                            rvalid;
   logic                            rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi4_sram_slave.sv
// Single-outstanding AXI4 memory target: FIXED/INCR/WRAP bursts of up to 256 beats
// over an internal word array, with alternating AW/AR priority.
module axi4_sram_slave #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH    = 128,
   parameter int AXI4_ID_WIDTH      = 4,
   parameter int MEM_ADDR_BITS      = 10
) (
   input  logic   clk,
   input  logic   rst,
   axi4_if.slave  s
);
   localparam int AW    = AXI4_ADDRESS_WIDTH;
   localparam int DW    = AXI4_DATA_WIDTH;
   localparam int NBYTE = DW / 8;
   localparam int LB    = $clog2(NBYTE);
   localparam int DEPTH = 1 << MEM_ADDR_BITS;
   localparam logic [2:0] LB3 = 3'(LB);

   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

   state_t                    state_q, state_d;
   logic                      prio_w_q;
   logic [AXI4_ID_WIDTH-1:0]  id_q;
   logic [AW-1:0]             addr_q;
   logic [7:0]                len_q, beat_q;
   logic [2:0]                size_q;
   logic [1:0]                burst_q;
   logic                      err_q;
   logic [DW-1:0]             rdata_q;
   logic                      rvalid_q, rlast_q;

   logic [DW-1:0]             mem [DEPTH];

   logic                      grant_w, grant_r, aw_hs, ar_hs, w_hs, r_hs, last_beat;
   logic [AXI4_ID_WIDTH-1:0]  req_id;
   logic [AW-1:0]             req_addr;
   logic [7:0]                req_len;
   logic [2:0]                req_size;
   logic [1:0]                req_burst, req_burst_eff;
   logic                      req_wrap_bad, req_err;
   logic [AW-1:0]             nb, wrap_mask, next_addr;
   logic [MEM_ADDR_BITS-1:0]  wr_idx, rd_idx;
   logic                      mem_we;

   assign grant_w = s.awvalid && (!s.arvalid || prio_w_q);
   assign grant_r = s.arvalid && !grant_w;
   assign aw_hs   = s.awready && s.awvalid;
   assign ar_hs   = s.arready && s.arvalid;
   assign w_hs    = (state_q == WDATA) && s.wvalid;
   assign r_hs    = rvalid_q && s.rready;
   assign last_beat = (beat_q == len_q);

   // Only one address can be granted per cycle, so both channels share one latch path.
   assign req_id    = grant_w ? s.awid    : s.arid;
   assign req_addr  = grant_w ? s.awaddr  : s.araddr;
   assign req_len   = grant_w ? s.awlen   : s.arlen;
   assign req_size  = grant_w ? s.awsize  : s.arsize;
   assign req_burst = grant_w ? s.awburst : s.arburst;

   assign req_wrap_bad  = (req_burst == 2'b10) &&
                          !(req_len inside {8'd1, 8'd3, 8'd7, 8'd15});
   assign req_err       = (req_size > LB3) || (req_burst == 2'b11) || req_wrap_bad;
   assign req_burst_eff = ((req_burst == 2'b11) || req_wrap_bad) ? 2'b01 : req_burst;

   assign nb        = AW'(1) << size_q;
   assign wrap_mask = (nb * (AW'(len_q) + AW'(1))) - AW'(1);

   always_comb begin
      next_addr = addr_q;
      case (burst_q)
         2'b00:   next_addr = addr_q;
         2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + nb) & wrap_mask);
         default: next_addr = (addr_q & ~(nb - AW'(1))) + nb;
      endcase
   end

   assign wr_idx = addr_q[MEM_ADDR_BITS+LB-1:LB];
   assign rd_idx = (state_q == IDLE) ? s.araddr[MEM_ADDR_BITS+LB-1:LB]
                                     : next_addr[MEM_ADDR_BITS+LB-1:LB];
   assign mem_we = w_hs && !err_q && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (aw_hs)      state_d = WDATA;
            else if (ar_hs) state_d = RDATA;
         end
         WDATA:   if (s.wvalid && last_beat) state_d = WRESP;
         WRESP:   if (s.bready)              state_d = IDLE;
         RDATA:   if (s.rready && rlast_q)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s.awready = 1'b0;
      s.arready = 1'b0;
      s.wready  = 1'b0;
      s.bvalid  = 1'b0;
      s.bid     = '0;
      s.bresp   = 2'b00;
      case (state_q)
         IDLE: begin
            s.awready = grant_w;
            s.arready = grant_r;
         end
         WDATA: s.wready = 1'b1;
         WRESP: begin
            s.bvalid = 1'b1;
            s.bid    = id_q;
            s.bresp  = err_q ? 2'b10 : 2'b00;
         end
         default: ;
      endcase
   end

   assign s.rvalid = rvalid_q;
   assign s.rdata  = rdata_q;
   assign s.rlast  = rlast_q;
   assign s.rid    = id_q;
   assign s.rresp  = (rvalid_q && err_q) ? 2'b10 : 2'b00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_w_q <= 1'b1;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
      end else begin
         if (aw_hs || ar_hs) begin
            prio_w_q <= ~prio_w_q;
            id_q     <= req_id;
            addr_q   <= req_addr;
            len_q    <= req_len;
            size_q   <= req_size;
            burst_q  <= req_burst_eff;
            beat_q   <= '0;
            err_q    <= req_err;
         end
         if (ar_hs) begin
            rdata_q  <= mem[rd_idx];
            rvalid_q <= 1'b1;
            rlast_q  <= (s.arlen == 8'd0);
         end
         // The beat counter decides where the burst ends; WLAST only flags a protocol error.
         if (w_hs) begin
            if (s.wlast != last_beat) err_q <= 1'b1;
            if (!last_beat) begin
               beat_q <= beat_q + 8'd1;
               addr_q <= next_addr;
            end
         end
         if (r_hs) begin
            if (rlast_q) begin
               rvalid_q <= 1'b0;
            end else begin
               beat_q  <= beat_q + 8'd1;
               addr_q  <= next_addr;
               rdata_q <= mem[rd_idx];
               rlast_q <= ((beat_q + 8'd1) == len_q);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NBYTE; b++) begin
            if (s.wstrb[b]) mem[wr_idx][b*8 +: 8] <= s.wdata[b*8 +: 8];
         end
      end
   end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: write/read bursts, WRAP ordering, arbitration,
// error responses and mid-burst reset, with hand-computed expectations.
module tb_axi4_sram_slave;
   localparam int AW = 32;
   localparam int DW = 128;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi4_if #(.AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) bus ();

   axi4_sram_slave #(
      .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW),
      .AXI4_ID_WIDTH(IW), .MEM_ADDR_BITS(10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .s   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]   wbuf [16];
   logic [DW-1:0]   rbuf [16];
   logic [1:0]      rresp_buf [16];
   logic            rlast_buf [16];
   logic [IW-1:0]   rid_got, bid_got;
   logic [1:0]      bresp_got;
   logic [DW/8-1:0] strb_g;
   logic [DW-1:0]   hold;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic aw_phase(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      @(negedge clk);
      bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
      bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
      #1;
      while (!bus.awready && n < 20) begin @(negedge clk); #1; n++; end
      check_eq("aw_ready", DW'(bus.awready), DW'(1));
      @(posedge clk); #1 bus.awvalid = 1'b0;
   endtask

   task automatic w_phase(input int len, input int early);
      for (int i = 0; i <= len; i++) begin
         @(negedge clk);
         bus.wdata = wbuf[i]; bus.wstrb = strb_g;
         bus.wlast = (early >= 0) ? (i == early) : (i == len);
         bus.wvalid = 1'b1;
         #1 check_eq("w_ready", DW'(bus.wready), DW'(1));
         @(posedge clk);
      end
      #1 bus.wvalid = 1'b0; bus.wlast = 1'b0;
   endtask

   task automatic b_phase();
      @(negedge clk);
      #1 check_eq("b_valid", DW'(bus.bvalid), DW'(1));
      bresp_got = bus.bresp; bid_got = bus.bid;
      bus.bready = 1'b1;
      @(posedge clk); #1 bus.bready = 1'b0;
   endtask

   task automatic ar_phase(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      @(negedge clk);
      bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
      bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
      #1;
      while (!bus.arready && n < 20) begin @(negedge clk); #1; n++; end
      check_eq("ar_ready", DW'(bus.arready), DW'(1));
      @(posedge clk); #1 bus.arvalid = 1'b0;
   endtask

   task automatic r_phase(input int len, input bit toggle, input int nbeats);
      @(negedge clk);
      #1 check_eq("r_valid_first", DW'(bus.rvalid), DW'(1));
      rid_got = bus.rid;
      for (int i = 0; i < nbeats; i++) begin
         if (toggle) begin
            bus.rready = 1'b0;
            hold = bus.rdata;
            @(negedge clk); #1;
            check_eq("r_stable", bus.rdata, hold);
            check_eq("r_valid_stall", DW'(bus.rvalid), DW'(1));
         end
         bus.rready = 1'b1;
         rbuf[i] = bus.rdata; rlast_buf[i] = bus.rlast; rresp_buf[i] = bus.rresp;
         check_eq("r_valid", DW'(bus.rvalid), DW'(1));
         @(posedge clk); @(negedge clk); #1;
      end
      bus.rready = 1'b0;
      if (nbeats == len + 1) check_eq("r_valid_done", DW'(bus.rvalid), DW'(0));
   endtask

   task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int early);
      aw_phase(id, addr, len, size, burst);
      w_phase(len, early);
      b_phase();
      $display("WRITE id=%0h addr=%h len=%0d size=%0d burst=%0d -> bid=%0h bresp=%0d",
               id, addr, len, size, burst, bid_got, bresp_got);
   endtask

   task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle);
      ar_phase(id, addr, len, size, burst);
      r_phase(len, toggle, len + 1);
      $display("READ  id=%0h addr=%h len=%0d size=%0d burst=%0d -> rid=%0h first=%0h rresp=%0d",
               id, addr, len, size, burst, rid_got, rbuf[0], rresp_buf[0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
      bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
      bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      strb_g = '1;

      // Reset values
      repeat (3) @(negedge clk);
      check_eq("rst_awready", DW'(bus.awready), DW'(0));
      check_eq("rst_arready", DW'(bus.arready), DW'(0));
      check_eq("rst_wready",  DW'(bus.wready),  DW'(0));
      check_eq("rst_bvalid",  DW'(bus.bvalid),  DW'(0));
      check_eq("rst_rvalid",  DW'(bus.rvalid),  DW'(0));
      check_eq("rst_rlast",   DW'(bus.rlast),   DW'(0));
      check_eq("rst_rdata",   bus.rdata,        DW'(0));
      check_eq("rst_bresp",   DW'(bus.bresp),   DW'(0));
      rst = 1'b0;

      // W beat offered in IDLE must not be accepted
      @(negedge clk);
      bus.wvalid = 1'b1;
      #1 check_eq("idle_wready", DW'(bus.wready), DW'(0));
      bus.wvalid = 1'b0;

      // Single write then read
      wbuf[0] = {96'h0, 32'hDEADBEEF};
      do_write(4'h5, 32'h40, 0, 3'd4, 2'b01, -1);
      check_eq("single_bresp", DW'(bresp_got), DW'(0));
      check_eq("single_bid",   DW'(bid_got),   DW'(5));
      do_read(4'h3, 32'h40, 0, 3'd4, 2'b01, 1'b0);
      check_eq("single_rdata", rbuf[0], {96'h0, 32'hDEADBEEF});
      check_eq("single_rlast", DW'(rlast_buf[0]), DW'(1));
      check_eq("single_rid",   DW'(rid_got), DW'(3));
      check_eq("single_rresp", DW'(rresp_buf[0]), DW'(0));

      // INCR 4-beat write, read back with RREADY toggling
      for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
      do_write(4'h1, 32'h100, 3, 3'd4, 2'b01, -1);
      check_eq("incr_bresp", DW'(bresp_got), DW'(0));
      do_read(4'h2, 32'h100, 3, 3'd4, 2'b01, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check_eq("incr_rdata", rbuf[i], DW'(i + 1));
         check_eq("incr_rlast", DW'(rlast_buf[i]), DW'(i == 3));
      end

      // WRAP read over words 0x10..0x13 holding their own index
      for (int i = 0; i < 4; i++) wbuf[i] = DW'(16 + i);
      do_write(4'h1, 32'h100, 3, 3'd4, 2'b01, -1);
      do_read(4'h4, 32'h120, 3, 3'd4, 2'b10, 1'b0);
      check_eq("wrap_b0", rbuf[0], DW'(32'h12));
      check_eq("wrap_b1", rbuf[1], DW'(32'h13));
      check_eq("wrap_b2", rbuf[2], DW'(32'h10));
      check_eq("wrap_b3", rbuf[3], DW'(32'h11));
      check_eq("wrap_rlast", DW'(rlast_buf[3]), DW'(1));
      check_eq("wrap_rlast_mid", DW'(rlast_buf[2]), DW'(0));

      // Simultaneous AW/AR twice: write wins each time, read follows and sees the write
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         bus.awid = 4'h1; bus.awaddr = 32'h200; bus.awlen = 8'd0; bus.awsize = 3'd4;
         bus.awburst = 2'b01; bus.awvalid = 1'b1;
         bus.arid = 4'h2; bus.araddr = 32'h200; bus.arlen = 8'd0; bus.arsize = 3'd4;
         bus.arburst = 2'b01; bus.arvalid = 1'b1;
         #1 check_eq("pair_awready", DW'(bus.awready), DW'(1));
         check_eq("pair_arready_blocked", DW'(bus.arready), DW'(0));
         @(posedge clk); #1 bus.awvalid = 1'b0;
         wbuf[0] = DW'(32'hA000 + k);
         w_phase(0, -1);
         b_phase();
         @(negedge clk);
         #1 check_eq("pair_arready", DW'(bus.arready), DW'(1));
         @(posedge clk); #1 bus.arvalid = 1'b0;
         r_phase(0, 1'b0, 1);
         check_eq("pair_rdata", rbuf[0], DW'(32'hA000 + k));
         $display("PAIR  round=%0d bresp=%0d rdata=%0h", k, bresp_got, rbuf[0]);
      end

      // AWSIZE beyond bus width: error response, memory untouched
      wbuf[0] = DW'(32'h1111);
      do_write(4'h6, 32'h40, 0, 3'd5, 2'b01, -1);
      check_eq("size_bresp", DW'(bresp_got), DW'(2));
      check_eq("size_bid",   DW'(bid_got),   DW'(6));
      do_read(4'h3, 32'h40, 0, 3'd4, 2'b01, 1'b0);
      check_eq("size_mem_kept", rbuf[0], {96'h0, 32'hDEADBEEF});

      // Reserved ARBURST: SLVERR on every beat, addresses advance as INCR
      do_read(4'h7, 32'h100, 1, 3'd4, 2'b11, 1'b0);
      check_eq("rsv_rresp0", DW'(rresp_buf[0]), DW'(2));
      check_eq("rsv_rresp1", DW'(rresp_buf[1]), DW'(2));
      check_eq("rsv_rdata1", rbuf[1], DW'(32'h11));

      // Early WLAST on beat 1 of a 4-beat burst
      for (int i = 0; i < 4; i++) wbuf[i] = DW'(32'hC0 + i);
      do_write(4'h8, 32'h300, 3, 3'd4, 2'b01, 1);
      check_eq("wlast_bresp", DW'(bresp_got), DW'(2));
      check_eq("wlast_bid",   DW'(bid_got),   DW'(8));

      // Reset during beat 2 of an 8-beat read
      ar_phase(4'h9, 32'h100, 7, 3'd4, 2'b01);
      r_phase(7, 1'b0, 2);
      check_eq("mid_b0", rbuf[0], DW'(32'h10));
      check_eq("mid_b1", rbuf[1], DW'(32'h11));
      rst = 1'b1;
      #1 check_eq("mid_rst_rvalid", DW'(bus.rvalid), DW'(0));
      check_eq("mid_rst_rdata", bus.rdata, DW'(0));
      @(negedge clk);
      rst = 1'b0;
      $display("RESET asserted mid-burst and released");
      @(negedge clk);
      bus.arid = 4'hA; bus.araddr = 32'h40; bus.arlen = 8'd0; bus.arsize = 3'd4;
      bus.arburst = 2'b01; bus.arvalid = 1'b1;
      #1 check_eq("post_rst_arready", DW'(bus.arready), DW'(1));
      @(posedge clk); #1 bus.arvalid = 1'b0;
      r_phase(0, 1'b0, 1);
      check_eq("post_rst_rdata", rbuf[0], {96'h0, 32'hDEADBEEF});
      check_eq("post_rst_rid", DW'(rid_got), DW'(4'hA));
      $display("READ  id=a addr=00000040 after reset -> rdata=%0h", rbuf[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi4_sram_slave.md
# axi4_sram_slave

Single-outstanding AXI4 responder backed by an internal register-array memory of 2^MEM_ADDR_BITS words of AXI4_DATA_WIDTH bits. Attaches to the slave modport of axi4_if and completes FIXED, INCR and WRAP bursts of 1–256 beats. It is the target end of the bus: bus-functional memory for benches and a simple on-chip RAM for subsystems driven by an AXI4 master.

## Interface
- AXI4_ADDRESS_WIDTH, 32, address width; must match the attached axi4_if.
- AXI4_DATA_WIDTH, 128, data width in bits; power of two, at least 32.
- AXI4_ID_WIDTH, 4, ID width.
- MEM_ADDR_BITS, 10, log2 of memory depth in bus words.
- clk  input  1  sole clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- s  interface  axi4_if.slave  AXI4 target port. Drives AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST and RVALID. All other AXI4 signals are inputs.

## Operation
- Word index = ADDR[MEM_ADDR_BITS+LB-1 : LB], where LB = log2(AXI4_DATA_WIDTH/8). Higher address bits are ignored, so addresses alias.
- State machine states: IDLE, WDATA, WRESP, RDATA. Exactly one transaction is in flight at a time.
- IDLE arbitration:
  - grant_w = AWVALID && (!ARVALID || prio_w).
  - grant_r = ARVALID && !grant_w.
  - AWREADY = (IDLE && grant_w). ARREADY = (IDLE && grant_r). Both are combinational from state and VALID.
  - prio_w resets to 1 and flips after every granted address, so simultaneous requests alternate.
- Address handshake latches ID, ADDR, LEN, SIZE and BURST, clears the beat counter, and sets the error flag err.
- err is set if any of these hold:
  - SIZE > LB;
  - BURST == 2'b11 (then treated as INCR);
  - BURST == WRAP with LEN not in {1,3,7,15} (then treated as INCR).
- Next-address rules, with nb = 1 << SIZE:
  - FIXED: address unchanged.
  - INCR: (addr & ~(nb-1)) + nb.
  - WRAP: boundary B = nb*(LEN+1). base = addr & ~(B-1). next = base | ((addr+nb) & (B-1)).
- IDLE → WDATA on AW handshake. WREADY = 1 throughout WDATA.
  - Each W beat writes the bytes enabled by WSTRB at the current word, unless err is set, in which case the write is suppressed.
  - A mismatch between WLAST and (beat == LEN) sets err. The beat count is authoritative.
  - Beat LEN → WRESP.
- WRESP: BVALID = 1, BID = latched ID, BRESP = err ? 2'b10 : 2'b00. BVALID holds until BREADY; the handshake → IDLE.
- IDLE → RDATA on AR handshake. RDATA register loads mem[start word], RVALID ← 1, RLAST ← (LEN == 0), RID ← ARID.
  - On each R handshake: if not last, load the next word and update RLAST; if last, RVALID ← 0 and → IDLE.
  - RRESP = err ? 2'b10 : 2'b00 on every beat.
  - Reads return the full bus word regardless of SIZE.
- Narrow writes rely on the master's WSTRB. The block does not mask lanes by SIZE.

## Timing
- Reset values: all READY and VALID outputs 0; BID, BRESP, RID, RDATA, RRESP, RLAST 0; state IDLE; prio_w 1. Memory contents are not reset.
- Reset asserted mid-burst: the in-flight transaction is abandoned within the same clock, outputs return to reset values, and no further memory writes occur.
- Write:
  - AW handshake at cycle N; WREADY high from N+1.
  - One beat per cycle when WVALID is held.
  - Last W handshake at cycle M; BVALID at M+1.
- Read:
  - AR handshake at cycle N; first RVALID and RDATA at N+1.
  - With RREADY held, one beat per cycle; the last beat of a LEN = L burst is at N+1+L.
  - RVALID and RDATA stay stable under backpressure.
- After the B or final-R handshake at cycle K, state is IDLE at K+1, and a new address can be accepted at K+1.
- A read issued after a write response sees the written data.
- W beats that arrive in IDLE are not accepted (WREADY = 0).

## Test plan
- Single write then read:
  - AW addr 0x40, LEN 0, SIZE 4, WDATA 0x…DEADBEEF, WSTRB all ones → BRESP 0, BID = AWID.
  - AR 0x40 → RDATA 0x…DEADBEEF, RLAST 1, RVALID at N+1.
- INCR write then read:
  - Write 4 beats at 0x100 with data 1, 2, 3, 4.
  - Read LEN 3 with RREADY toggled every other cycle → RDATA 1, 2, 3, 4, RLAST only on beat 4, data stable while stalled.
- WRAP read: LEN 3, SIZE 4, start 0x120, over memory filled with word index → word order 0x12, 0x13, 0x10, 0x11 (words 0x10–0x13 hold their own index).
- Simultaneous AWVALID and ARVALID after reset → write granted first and read second. Repeat the pair → write granted first again, since priority alternates every grant.
- Error responses:
  - AWSIZE 5 on a 128-bit bus → BRESP 2'b10, memory unchanged.
  - ARBURST 2'b11 → RRESP 2'b10 on every beat.
  - WLAST early on beat 1 of a LEN 3 burst → 4 beats still accepted, BRESP 2'b10.
- Reset asserted during beat 2 of an 8-beat read:
  - RVALID 0 immediately.
  - After release, ARREADY is high in IDLE and a new read completes correctly.
